// File: rtl/epp_pkg.sv
// Shared definitions for the EPP register bank: FSM encodings, state-field
// bit positions and the address decode helper.
package epp_pkg;

  typedef logic [3:0] epp_state_t;

  // Field bits: ACT marks a live transaction, DIR a host read, WAIT a B state.
  localparam int unsigned ST_ACT_BIT  = 0;
  localparam int unsigned ST_DIR_BIT  = 2;
  localparam int unsigned ST_WAIT_BIT = 3;

  localparam epp_state_t ST_IDLE  = 4'b0000;
  localparam epp_state_t ST_AWR_A = 4'b0001;
  localparam epp_state_t ST_DWR_A = 4'b0011;
  localparam epp_state_t ST_ARD_A = 4'b0101;
  localparam epp_state_t ST_DRD_A = 4'b0111;
  localparam epp_state_t ST_AWR_B = 4'b1001;
  localparam epp_state_t ST_DWR_B = 4'b1011;
  localparam epp_state_t ST_ARD_B = 4'b1101;
  localparam epp_state_t ST_DRD_B = 4'b1111;

  typedef enum logic [1:0] {
    AK_RW,
    AK_RO,
    AK_NONE
  } addr_kind_t;

  function automatic addr_kind_t decode_addr(input int unsigned addr,
                                             input int unsigned num_rw,
                                             input int unsigned num_ro);
    if (addr < num_rw) return AK_RW;
    if (addr < num_rw + num_ro) return AK_RO;
    return AK_NONE;
  endfunction

endpackage

// File: rtl/epp_sync.sv
// Multi-flop synchroniser for one asynchronous EPP control line; resets high
// so idle (high) strobes never look active while leaving reset.
module epp_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff <= '1;
    end else begin
      r_ff <= {r_ff[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/epp_regbank.sv
// EPP slave register bank: RW registers and RO status inputs in one address
// space, with synchronised strobes, optional auto-increment and fabric strobes.
module epp_regbank
  import epp_pkg::*;
#(
  parameter int unsigned NUM_RW      = 8,
  parameter int unsigned NUM_RO      = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AUTO_INC    = 1,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     EppAstb,
  input  logic                                     EppDstb,
  input  logic                                     EppWr,
  output logic                                     EppWait,
  inout  logic [7:0]                               EppDB,
  output logic [NUM_RW*8-1:0]                      regs_q,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*8-1:0] ro_data,
  output logic [NUM_RW-1:0]                        wr_stb,
  output logic [((NUM_RO > 0) ? NUM_RO : 1)-1:0]   rd_stb,
  output logic [ADDR_W-1:0]                        cur_addr
);

  logic                                   w_sastb;
  logic                                   w_sdstb;
  logic                                   w_swr;
  logic                                   w_rd_drv;
  logic [7:0]                             w_rd_data;
  addr_kind_t                             w_kind;
  epp_state_t                             r_state;
  logic [ADDR_W-1:0]                      r_addr;
  logic [NUM_RW*8-1:0]                    r_regs;
  logic [7:0]                             r_rd_latch;
  logic [NUM_RW-1:0]                      r_wr_stb;
  logic [((NUM_RO > 0) ? NUM_RO : 1)-1:0] r_rd_stb;

  epp_sync #(.STAGES(SYNC_STAGES)) u_sync_astb (
    .clk(clk), .rst_n(rst_n), .i_d(EppAstb), .o_q(w_sastb)
  );
  epp_sync #(.STAGES(SYNC_STAGES)) u_sync_dstb (
    .clk(clk), .rst_n(rst_n), .i_d(EppDstb), .o_q(w_sdstb)
  );
  epp_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .rst_n(rst_n), .i_d(EppWr), .o_q(w_swr)
  );

  always_comb begin
    w_kind    = decode_addr(32'(r_addr), NUM_RW, NUM_RO);
    w_rd_data = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (w_kind == AK_RW && 32'(r_addr) == i) w_rd_data = r_regs[8*i +: 8];
    end
    for (int unsigned j = 0; j < NUM_RO; j++) begin
      if (w_kind == AK_RO && 32'(r_addr) == NUM_RW + j) w_rd_data = ro_data[8*j +: 8];
    end
  end

  // Strobes return to IDLE only from B states, so the synced direction is
  // sampled once at IDLE and later changes cannot redirect the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_regs     <= {NUM_RW{RESET_VAL}};
      r_rd_latch <= '0;
      r_wr_stb   <= '0;
      r_rd_stb   <= '0;
    end else begin
      r_wr_stb <= '0;
      r_rd_stb <= '0;
      case (r_state)
        ST_IDLE: begin
          if (!w_sastb) begin
            r_state <= w_swr ? ST_ARD_A : ST_AWR_A;
            if (w_swr) r_rd_latch <= 8'(r_addr);
          end else if (!w_sdstb) begin
            r_state <= w_swr ? ST_DRD_A : ST_DWR_A;
            if (w_swr) begin
              r_rd_latch <= w_rd_data;
              for (int unsigned j = 0; j < NUM_RO; j++) begin
                if (w_kind == AK_RO && 32'(r_addr) == NUM_RW + j) r_rd_stb[j] <= 1'b1;
              end
            end
          end
        end
        ST_AWR_A: begin
          r_addr  <= EppDB[ADDR_W-1:0];
          r_state <= ST_AWR_B;
        end
        ST_DWR_A: begin
          for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (w_kind == AK_RW && 32'(r_addr) == i) begin
              r_regs[8*i +: 8] <= EppDB;
              r_wr_stb[i]      <= 1'b1;
            end
          end
          r_state <= ST_DWR_B;
        end
        ST_ARD_A: r_state <= ST_ARD_B;
        ST_DRD_A: r_state <= ST_DRD_B;
        ST_AWR_B, ST_ARD_B: begin
          if (w_sastb) r_state <= ST_IDLE;
        end
        ST_DWR_B, ST_DRD_B: begin
          if (w_sdstb) begin
            r_state <= ST_IDLE;
            if (AUTO_INC != 0) r_addr <= r_addr + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_rd_drv = r_state[ST_DIR_BIT] & r_state[ST_ACT_BIT] & EppWr;
  assign EppWait  = r_state[ST_WAIT_BIT] & r_state[ST_ACT_BIT];
  assign EppDB    = w_rd_drv ? r_rd_latch : 'z;
  assign regs_q   = r_regs;
  assign wr_stb   = r_wr_stb;
  assign rd_stb   = r_rd_stb;
  assign cur_addr = r_addr;

endmodule

// File: tb/tb_epp_regbank.sv
// Randomised host-side bench for epp_regbank with a transaction-level model
// of the register map; a narrow-address pair checks wrap and no-increment.
module tb_epp_regbank;

  localparam int unsigned SYNC = 2;
  localparam logic [7:0]  RV   = 8'h5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic astb = 1'b1;
  logic dstb = 1'b1;
  logic wr = 1'b1;
  logic host_en = 1'b0;
  logic [7:0] host_val = '0;
  logic [31:0] ro_data = '0;

  wire [7:0] db_m, db_i, db_n;
  assign db_m = host_en ? host_val : 8'hzz;
  assign db_i = host_en ? host_val : 8'hzz;
  assign db_n = host_en ? host_val : 8'hzz;

  logic        wait_m, wait_i, wait_n;
  logic [63:0] regs_m, regs_i, regs_n;
  logic [7:0]  wrs_m, wrs_i, wrs_n;
  logic [3:0]  rds_m, rds_i, rds_n;
  logic [7:0]  addr_m;
  logic [3:0]  addr_i, addr_n;

  epp_regbank #(.NUM_RW(8), .NUM_RO(4), .ADDR_W(8), .SYNC_STAGES(SYNC), .AUTO_INC(1), .RESET_VAL(RV)) u_dut (
    .clk(clk), .rst_n(rst_n), .EppAstb(astb), .EppDstb(dstb), .EppWr(wr), .EppWait(wait_m),
    .EppDB(db_m), .regs_q(regs_m), .ro_data(ro_data), .wr_stb(wrs_m), .rd_stb(rds_m), .cur_addr(addr_m)
  );
  epp_regbank #(.NUM_RW(8), .NUM_RO(4), .ADDR_W(4), .SYNC_STAGES(SYNC), .AUTO_INC(1), .RESET_VAL(8'h00)) u_dut_inc4 (
    .clk(clk), .rst_n(rst_n), .EppAstb(astb), .EppDstb(dstb), .EppWr(wr), .EppWait(wait_i),
    .EppDB(db_i), .regs_q(regs_i), .ro_data(ro_data), .wr_stb(wrs_i), .rd_stb(rds_i), .cur_addr(addr_i)
  );
  epp_regbank #(.NUM_RW(8), .NUM_RO(4), .ADDR_W(4), .SYNC_STAGES(SYNC), .AUTO_INC(0), .RESET_VAL(8'h00)) u_dut_noinc4 (
    .clk(clk), .rst_n(rst_n), .EppAstb(astb), .EppDstb(dstb), .EppWr(wr), .EppWait(wait_n),
    .EppDB(db_n), .regs_q(regs_n), .ro_data(ro_data), .wr_stb(wrs_n), .rd_stb(rds_n), .cur_addr(addr_n)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] m_regs [8];
  logic [7:0] m_addr;
  logic [3:0] m_ai, m_an;

  logic [7:0]  acc_wr, wr_at_rise, db_at_rise;
  logic [3:0]  acc_rd;
  int unsigned n_wr, n_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_pack();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = RV;
    m_addr = '0;
    m_ai   = '0;
    m_an   = '0;
  endtask

  task automatic chk_addrs(input string pfx);
    chk({pfx, "_addr"}, 64'(addr_m), 64'(m_addr));
    chk({pfx, "_addr_inc4"}, 64'(addr_i), 64'(m_ai));
    chk({pfx, "_addr_noinc4"}, 64'(addr_n), 64'(m_an));
  endtask

  task automatic wait_for(input logic lvl, output int unsigned cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int unsigned k = 0; k < 20; k++) begin
      @(negedge clk);
      cyc++;
      acc_wr |= wrs_m;
      acc_rd |= rds_m;
      if (wrs_m != 0) n_wr++;
      if (rds_m != 0) n_rd++;
      if (wait_m == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic epp_cycle(input bit is_addr, input bit is_rd, input logic [7:0] wval);
    int unsigned cyc;
    bit ok;
    acc_wr = '0;
    acc_rd = '0;
    n_wr   = 0;
    n_rd   = 0;
    @(negedge clk);
    wr       = is_rd;
    host_en  = !is_rd;
    host_val = wval;
    if (is_addr) astb = 1'b0;
    else dstb = 1'b0;
    wait_for(1'b1, cyc, ok);
    chk("wait_rise", 64'(ok), 64'd1);
    if (ok) chk("latency", 64'(cyc), 64'(SYNC + 2));
    wr_at_rise = wrs_m;
    db_at_rise = db_m;
    astb = 1'b1;
    dstb = 1'b1;
    wait_for(1'b0, cyc, ok);
    chk("wait_fall", 64'(ok), 64'd1);
    host_en = 1'b0;
    wr      = 1'b1;
  endtask

  task automatic do_addr_wr(input logic [7:0] a);
    epp_cycle(1'b1, 1'b0, a);
    m_addr = a;
    m_ai   = a[3:0];
    m_an   = a[3:0];
    chk("aw_strobes", 64'(n_wr + n_rd), 64'd0);
    chk_addrs("aw");
  endtask

  task automatic do_addr_rd();
    epp_cycle(1'b1, 1'b1, 8'h00);
    chk("ar_data", 64'(db_at_rise), 64'(m_addr));
    chk("ar_strobes", 64'(n_wr + n_rd), 64'd0);
    chk_addrs("ar");
  endtask

  task automatic do_data_wr(input logic [7:0] v);
    logic [7:0] exp_wr;
    exp_wr = '0;
    if (m_addr < 8) begin
      exp_wr[m_addr[2:0]] = 1'b1;
      m_regs[m_addr[2:0]] = v;
    end
    epp_cycle(1'b0, 1'b0, v);
    chk("dw_stb_at_wait", 64'(wr_at_rise), 64'(exp_wr));
    chk("dw_stb_cycles", 64'(n_wr), (exp_wr != 0) ? 64'd1 : 64'd0);
    chk("dw_no_rd", 64'(acc_rd), 64'd0);
    chk("dw_regs", regs_m, m_pack());
    m_addr = m_addr + 8'd1;
    m_ai   = m_ai + 4'd1;
    chk_addrs("dw");
  endtask

  task automatic do_data_rd();
    logic [7:0] exp_v;
    logic [3:0] exp_rd;
    exp_v  = '0;
    exp_rd = '0;
    if (m_addr < 8) exp_v = m_regs[m_addr[2:0]];
    else if (m_addr < 12) begin
      exp_v = ro_data[8*(int'(m_addr) - 8) +: 8];
      exp_rd[m_addr[1:0]] = 1'b1;
    end
    epp_cycle(1'b0, 1'b1, 8'h00);
    chk("dr_data", 64'(db_at_rise), 64'(exp_v));
    chk("dr_rd_stb", 64'(acc_rd), 64'(exp_rd));
    chk("dr_rd_cycles", 64'(n_rd), (exp_rd != 0) ? 64'd1 : 64'd0);
    chk("dr_no_wr", 64'(acc_wr), 64'd0);
    chk("dr_regs", regs_m, m_pack());
    m_addr = m_addr + 8'd1;
    m_ai   = m_ai + 4'd1;
    chk_addrs("dr");
  endtask

  initial begin
    int unsigned cyc;
    bit ok;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_wait", 64'(wait_m), 64'd0);
    chk("rst_regs", regs_m, {8{RV}});
    chk("rst_regs_w4", regs_i, 64'd0);
    chk("rst_wr_stb", 64'(wrs_m), 64'd0);
    chk("rst_rd_stb", 64'(rds_m), 64'd0);
    chk_addrs("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_addr_wr(8'h02);
    do_data_wr(8'hA5);

    ro_data = 32'h1122_333C;
    do_addr_wr(8'h08);
    do_data_rd();

    do_addr_wr(8'h20);
    do_data_wr(8'h11);
    do_data_rd();

    do_addr_wr(8'h0F);
    do_data_wr(8'h77);
    do_addr_wr(8'hFF);
    do_data_wr(8'h42);

    // Both strobes low together: the address cycle must win.
    acc_wr = '0;
    n_wr   = 0;
    @(negedge clk);
    wr = 1'b0; host_en = 1'b1; host_val = 8'h06; astb = 1'b0; dstb = 1'b0;
    wait_for(1'b1, cyc, ok);
    chk("both_wait_rise", 64'(ok), 64'd1);
    astb = 1'b1; dstb = 1'b1;
    wait_for(1'b0, cyc, ok);
    host_en = 1'b0; wr = 1'b1;
    m_addr = 8'h06; m_ai = 4'h6; m_an = 4'h6;
    chk("both_no_wr", 64'(n_wr), 64'd0);
    chk("both_regs", regs_m, m_pack());
    chk_addrs("both");
    do_addr_rd();

    // Reset while the bank holds the host in DWR_B.
    do_addr_wr(8'h01);
    @(negedge clk);
    wr = 1'b0; host_en = 1'b1; host_val = 8'hC3; dstb = 1'b0;
    wait_for(1'b1, cyc, ok);
    chk("rstmid_wait_rise", 64'(ok), 64'd1);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rstmid_wait", 64'(wait_m), 64'd0);
    chk("rstmid_regs", regs_m, m_pack());
    chk("rstmid_wr_stb", 64'(wrs_m), 64'd0);
    chk("rstmid_bus", 64'(db_m), 64'hC3);
    chk_addrs("rstmid");
    @(negedge clk);
    dstb = 1'b1; host_en = 1'b0; wr = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_addr_wr(8'h01);
    do_data_wr(8'hC3);
    do_addr_wr(8'h01);
    do_data_rd();

    for (int unsigned t = 0; t < 120; t++) begin
      case ($urandom_range(0, 3))
        0: do_addr_wr(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 13)));
        1: do_data_wr(8'($urandom));
        2: begin
          ro_data = $urandom;
          do_data_rd();
        end
        default: do_addr_rd();
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
